fetch_queue: RTL

Instruction fetch stage and byte queue directly upstream of the decode stage. Issues line-aligned 16-byte requests to the instruction cache, buffers returned bytes in a 32-byte queue, and presents a 16-byte window (IR) with its EIP/CS to decode. Decode returns the length of the instruction it consumed; the queue retires those bytes and refills. Redirects from branch, interrupt or exception logic flush the queue and restart fetch.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_byte_align.sv | 48 ++++
 rtl/fetch_queue.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned LINE_BYTES  = 16;
    localparam int unsigned QUEUE_BYTES = 32;
    localparam int unsigned LINE_W      = 8 * LINE_BYTES;
    localparam int unsigned QUEUE_W     = 8 * QUEUE_BYTES;
    localparam int unsigned COUNT_W     = 6;

    localparam logic [31:0] RESET_EIP = 32'hFFFF_FFF0;
    localparam logic [15:0] RESET_CS  = 16'hF000;

    typedef enum logic [1:0] {
        ST_FETCH      = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:4], 4'h0};
    endfunction

endpackage

// File: rtl/fetch_byte_align.sv
// Combinational byte shifter: drops consumed bytes from the queue head and
// inserts the useful part of a returned line at a byte position.
module fetch_byte_align
    import fetch_pkg::*;
(
    input  logic [QUEUE_W-1:0] queue,
    input  logic [3:0]         shift,
    input  logic [LINE_W-1:0]  line,
    input  logic [3:0]         drop,
    input  logic [COUNT_W-1:0] ins_pos,
    input  logic               ins_en,
    output logic [QUEUE_W-1:0] result_c
);

    logic [7:0] qb [QUEUE_BYTES];
    logic [7:0] lb [LINE_BYTES];
    logic [4:0] fill_len;

    assign fill_len = 5'(LINE_BYTES) - {1'b0, drop};

    always_comb begin
        for (int i = 0; i < QUEUE_BYTES; i++) qb[i] = queue[8*i +: 8];
    end

    always_comb begin
        for (int i = 0; i < LINE_BYTES; i++) lb[i] = line[8*i +: 8];
    end

    // Byte i takes queue byte i+shift, unless it lies in the insertion window.
    always_comb begin
        logic [COUNT_W-1:0] src;
        logic [COUNT_W-1:0] rel;
        logic [7:0]         b;
        result_c = '0;
        src      = '0;
        rel      = '0;
        b        = '0;
        for (int i = 0; i < QUEUE_BYTES; i++) begin
            src = COUNT_W'(i) + COUNT_W'(shift);
            b   = (src < COUNT_W'(QUEUE_BYTES)) ? qb[src[4:0]] : 8'h00;
            rel = COUNT_W'(i) - ins_pos;
            if (ins_en && (COUNT_W'(i) >= ins_pos) && (rel < COUNT_W'(fill_len)))
                b = lb[4'(rel) + drop];
            result_c[8*i +: 8] = b;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage and 32-byte queue feeding a 16-byte window to decode.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              fetch_req,
    output logic [31:0]       fetch_addr,
    input  logic              icache_ready,
    input  logic [LINE_W-1:0] icache_data,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_eip,
    input  logic [15:0]       redirect_cs,
    output logic [LINE_W-1:0] IR,
    output logic [31:0]       EIP,
    output logic [15:0]       CS,
    output logic              ir_valid,
    input  logic              decode_ready,
    input  logic [3:0]        instr_length_updt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    state_e              state, state_next;
    logic [COUNT_W-1:0]  count, count_next, ins_pos, count_fill;
    logic [QUEUE_W-1:0]  queue, queue_next, aligned;
    logic [31:0]         pend_addr, pend_addr_next, fetch_addr_next, eip_next;
    logic [15:0]         cs_next;
    logic [3:0]          drop_offset, drop_next, len_eff;
    logic [4:0]          fill_len;
    logic                consume, accept, fill, space, outstanding;
    logic                fetch_req_next, ir_valid_next;

    assign consume     = ir_valid && decode_ready && (instr_length_updt != 4'd0);
    assign len_eff     = consume ? instr_length_updt : 4'd0;
    assign accept      = fetch_req && icache_ready;
    assign fill        = accept && (state == ST_FETCH);
    assign fill_len    = 5'(LINE_BYTES) - {1'b0, drop_offset};
    assign ins_pos     = count - COUNT_W'(len_eff);
    assign count_fill  = ins_pos + (fill ? COUNT_W'(fill_len) : COUNT_W'(0));
    assign space       = (count_fill + COUNT_W'(LINE_BYTES)) <= COUNT_W'(QUEUE_BYTES);
    assign outstanding = fetch_req && !icache_ready && (state != ST_WAIT_SPACE);

    fetch_byte_align u_align (
        .queue    (queue),
        .shift    (len_eff),
        .line     (icache_data),
        .drop     (drop_offset),
        .ins_pos  (ins_pos),
        .ins_en   (fill),
        .result_c (aligned)
    );

    // Next-state and datapath updates; redirect overrides consume and fill.
    always_comb begin
        state_next      = state;
        count_next      = count_fill;
        queue_next      = aligned;
        eip_next        = EIP + 32'(len_eff);
        cs_next         = CS;
        fetch_addr_next = fetch_addr;
        pend_addr_next  = pend_addr;
        drop_next       = drop_offset;

        case (state)
            ST_FETCH: begin
                if (fill) begin
                    fetch_addr_next = fetch_addr + 32'(LINE_BYTES);
                    drop_next       = 4'd0;
                    state_next      = space ? ST_FETCH : ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (space) state_next = ST_FETCH;
            end
            ST_FLUSH: begin
                if (accept) begin
                    state_next      = ST_FETCH;
                    fetch_addr_next = pend_addr;
                end
            end
            default: state_next = ST_FETCH;
        endcase

        if (redirect_valid) begin
            count_next     = '0;
            queue_next     = '0;
            eip_next       = redirect_eip;
            cs_next        = redirect_cs;
            pend_addr_next = line_base(redirect_eip);
            drop_next      = redirect_eip[3:0];
            if (outstanding) begin
                // Old request is still on the bus; keep its address until it is taken.
                state_next      = ST_FLUSH;
                fetch_addr_next = fetch_addr;
            end else begin
                state_next      = ST_FETCH;
                fetch_addr_next = line_base(redirect_eip);
            end
        end

        fetch_req_next = (state_next != ST_WAIT_SPACE);
        ir_valid_next  = (count_next >= COUNT_W'(LINE_BYTES)) && (state_next != ST_FLUSH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            queue       <= '0;
            EIP         <= RESET_EIP;
            CS          <= RESET_CS;
            fetch_addr  <= RESET_EIP;
            pend_addr   <= RESET_EIP;
            drop_offset <= 4'd0;
            fetch_req   <= 1'b0;
            ir_valid    <= 1'b0;
        end else begin
            count       <= count_next;
            queue       <= queue_next;
            EIP         <= eip_next;
            CS          <= cs_next;
            fetch_addr  <= fetch_addr_next;
            pend_addr   <= pend_addr_next;
            drop_offset <= drop_next;
            fetch_req   <= fetch_req_next;
            ir_valid    <= ir_valid_next;
        end
    end

    assign IR = queue[LINE_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of decode starvation and redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (decode_ready && !ir_valid && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect_valid && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule
